// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB encodings and arbiter state for the per-slave arbiter.
package ahb_arbiter_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BurstSingle = 3'd0,
    BurstIncr   = 3'd1,
    BurstWrap4  = 3'd2,
    BurstIncr4  = 3'd3,
    BurstWrap8  = 3'd4,
    BurstIncr8  = 3'd5,
    BurstWrap16 = 3'd6,
    BurstIncr16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    StIdle,
    StFixed,
    StUndef,
    StLocked
  } arb_state_t;

  localparam int unsigned BeatsW = 5;

  // Zero encodes an undefined-length (INCR) burst.
  function automatic logic [BeatsW-1:0] burst_len(hburst_t burst);
    logic [BeatsW-1:0] len;
    case (burst)
      BurstSingle:             len = 5'd1;
      BurstIncr:               len = 5'd0;
      BurstWrap4, BurstIncr4:  len = 5'd4;
      BurstWrap8, BurstIncr8:  len = 5'd8;
      default:                 len = 5'd16;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_arbiter_rr_picker.sv
// Round-robin picker: searches from the owner's successor, owner checked last.
module ahb_rr_picker #(
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned MIDX_W     = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] i_req,
  input  logic [MIDX_W-1:0]     i_own,
  output logic [MASTER_NUM-1:0] o_win,
  output logic                  o_found
);

  logic [MIDX_W:0] w_idx;

  always_comb begin
    o_win   = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= MASTER_NUM; k++) begin
      w_idx = {1'b0, i_own} + (MIDX_W+1)'(k);
      if (w_idx >= (MIDX_W+1)'(MASTER_NUM)) begin
        w_idx = w_idx - (MIDX_W+1)'(MASTER_NUM);
      end
      if (!o_found && i_req[w_idx[MIDX_W-1:0]]) begin
        o_win[w_idx[MIDX_W-1:0]] = 1'b1;
        o_found                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Per-slave AHB arbiter: grants address-phase ownership at burst boundaries
// and tracks the data-phase owner one accepted transfer behind.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned MIDX_W     = $clog2(MASTER_NUM)
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [MASTER_NUM-1:0]      hsel,
  input  logic [MASTER_NUM-1:0][1:0] htrans,
  input  logic [MASTER_NUM-1:0][2:0] hburst,
  input  logic [MASTER_NUM-1:0]      hmastlock,
  input  logic                       hready,
  output logic [MASTER_NUM-1:0]      addr_sel,
  output logic [MASTER_NUM-1:0]      data_sel,
  output logic [MIDX_W-1:0]          hmaster,
  output logic [MASTER_NUM-1:0]      stall
);

  arb_state_t              r_state, w_state_nxt;
  logic [BeatsW-1:0]       r_beats, w_beats_nxt;
  logic [MASTER_NUM-1:0]   r_addr_sel, r_data_sel;
  logic [MIDX_W-1:0]       r_hmaster, w_win_idx;
  logic [MASTER_NUM-1:0]   w_req, w_win;
  logic                    w_found, w_accept, w_arb, w_open;
  htrans_t                 w_own_trans;
  logic [BeatsW-1:0]       w_len;

  always_comb begin
    w_req = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      w_req[i] = hsel[i] & htrans[i][1];
    end
  end

  assign w_own_trans = htrans_t'(htrans[r_hmaster]);
  assign w_len       = burst_len(hburst_t'(hburst[r_hmaster]));
  assign w_accept    = hready & w_req[r_hmaster];
  assign w_open      = w_accept && (w_own_trans == TransNonseq);

  ahb_rr_picker #(
    .MASTER_NUM (MASTER_NUM),
    .MIDX_W     (MIDX_W)
  ) u_picker (
    .i_req   (w_req),
    .i_own   (r_hmaster),
    .o_win   (w_win),
    .o_found (w_found)
  );

  always_comb begin
    w_win_idx = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      if (w_win[i]) w_win_idx = MIDX_W'(i);
    end
  end

  // Only meaningful when hready=1; the register block ignores it otherwise.
  always_comb begin
    w_state_nxt = r_state;
    w_beats_nxt = r_beats;
    w_arb       = 1'b0;
    if (hmastlock[r_hmaster]) begin
      w_state_nxt = StLocked;
      w_beats_nxt = '0;
    end else begin
      if (w_open) begin
        // A new NONSEQ from the owner opens a burst instead of releasing.
        if (w_len == '0) begin
          w_state_nxt = StUndef;
          w_beats_nxt = '0;
        end else if (w_len > 5'd1) begin
          w_state_nxt = StFixed;
          w_beats_nxt = w_len - 5'd1;
        end else begin
          w_arb = 1'b1;
        end
      end else begin
        unique case (r_state)
          StFixed: begin
            if (w_accept && (w_own_trans == TransSeq)) begin
              if (r_beats <= 5'd1) w_arb = 1'b1;
              else                 w_beats_nxt = r_beats - 5'd1;
            end
          end
          StUndef: begin
            if (!w_req[r_hmaster] || (w_own_trans != TransSeq)) w_arb = 1'b1;
          end
          default: begin
            if (!w_req[r_hmaster]) w_arb = 1'b1;
          end
        endcase
      end
      if (w_arb) begin
        w_state_nxt = StIdle;
        w_beats_nxt = '0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state    <= StIdle;
      r_beats    <= '0;
      r_addr_sel <= {{(MASTER_NUM-1){1'b0}}, 1'b1};
      r_hmaster  <= '0;
      r_data_sel <= '0;
    end else if (hready) begin
      r_state    <= w_state_nxt;
      r_beats    <= w_beats_nxt;
      r_data_sel <= w_accept ? r_addr_sel : '0;
      if (w_arb && w_found) begin
        r_addr_sel <= w_win;
        r_hmaster  <= w_win_idx;
      end
    end
  end

  assign addr_sel = r_addr_sel;
  assign data_sel = r_data_sel;
  assign hmaster  = r_hmaster;
  assign stall    = w_req & ~r_addr_sel;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter with three masters: directed table, corner sequences
// and random traffic checked against a beat-counting reference model.
module tb_ahb_arbiter;

  logic           HCLK = 1'b0;
  logic           HRESETn;
  logic [2:0]     hsel;
  logic [2:0][1:0] htrans;
  logic [2:0][2:0] hburst;
  logic [2:0]     hmastlock;
  logic           hready;
  logic [2:0]     addr_sel, data_sel, stall;
  logic [1:0]     hmaster;

  always #5 HCLK = ~HCLK;

  ahb_arbiter #(
    .MASTER_NUM (3)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .hsel      (hsel),
    .htrans    (htrans),
    .hburst    (hburst),
    .hmastlock (hmastlock),
    .hready    (hready),
    .addr_sel  (addr_sel),
    .data_sel  (data_sel),
    .hmaster   (hmaster),
    .stall     (stall)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner index, data owner (-1 none), beats remaining, open INCR.
  int m_owner = 0;
  int m_data  = -1;
  int m_left  = 0;
  bit m_undef = 1'b0;
  int lens[8] = '{1, 0, 4, 4, 8, 8, 16, 16};

  typedef struct {
    logic [2:0] sel;
    logic [5:0] trans;
    logic [8:0] burst;
    logic [2:0] exp_stall;
    logic [2:0] exp_addr;
    logic [2:0] exp_data;
    logic [1:0] exp_hm;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [2:0] req_vec();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = hsel[i] & htrans[i][1];
    return r;
  endfunction

  function automatic logic [2:0] onehot(int i);
    if (i < 0) return 3'b000;
    return 3'(1 << i);
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [2:0] r;
    logic [1:0] o;
    logic [1:0] t;
    int         own, c;
    bit         rel, found;
    if (!HRESETn) begin
      m_owner = 0; m_data = -1; m_left = 0; m_undef = 1'b0;
      return;
    end
    if (!hready) return;
    own = m_owner;
    o   = own[1:0];
    r   = req_vec();
    t   = htrans[o];
    rel = 1'b0;
    m_data = r[o] ? own : -1;
    if (hmastlock[o]) begin
      m_left = 0; m_undef = 1'b0;
      return;
    end
    if (r[o] && t == 2'b10) begin
      if (lens[hburst[o]] == 0) begin
        m_undef = 1'b1; m_left = 0;
      end else if (lens[hburst[o]] == 1) begin
        rel = 1'b1;
      end else begin
        m_left = lens[hburst[o]] - 1; m_undef = 1'b0;
      end
    end else if (m_left > 0) begin
      if (r[o] && t == 2'b11) begin
        m_left--;
        rel = (m_left == 0);
      end
    end else if (m_undef) begin
      rel = !(r[o] && t == 2'b11);
    end else begin
      rel = !r[o];
    end
    if (rel) begin
      m_left = 0; m_undef = 1'b0; found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        c = (own + k) % 3;
        if (!found && r[c[1:0]]) begin
          m_owner = c; found = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input logic rst_v, input logic [2:0] s, input logic [5:0] t,
                       input logic [8:0] b, input logic [2:0] l, input logic rdy);
    HRESETn = rst_v; hsel = s; htrans = t; hburst = b; hmastlock = l; hready = rdy;
  endtask

  task automatic cycle(input bit chk_stall);
    #1;
    if (chk_stall) chk("stall", stall, req_vec() & ~onehot(m_owner));
    model_step();
    @(posedge HCLK);
    #1;
    chk("addr_sel", addr_sel, onehot(m_owner));
    chk("data_sel", data_sel, onehot(m_data));
    chk("hmaster", {1'b0, hmaster}, {1'b0, m_owner[1:0]});
  endtask

  initial begin
    tbl[0] = '{3'b111, 6'b10_10_10, 9'b0, 3'b110, 3'b010, 3'b001, 2'd1};
    tbl[1] = '{3'b111, 6'b10_10_10, 9'b0, 3'b101, 3'b100, 3'b010, 2'd2};
    tbl[2] = '{3'b111, 6'b10_10_10, 9'b0, 3'b011, 3'b001, 3'b100, 2'd0};
    tbl[3] = '{3'b111, 6'b10_10_10, 9'b0, 3'b110, 3'b010, 3'b001, 2'd1};
    tbl[4] = '{3'b110, 6'b10_10_00, 9'b000_011_000, 3'b100, 3'b010, 3'b010, 2'd1};
    tbl[5] = '{3'b110, 6'b10_11_00, 9'b000_011_000, 3'b100, 3'b010, 3'b010, 2'd1};
    tbl[6] = '{3'b110, 6'b10_11_00, 9'b000_011_000, 3'b100, 3'b010, 3'b010, 2'd1};
    tbl[7] = '{3'b110, 6'b10_11_00, 9'b000_011_000, 3'b100, 3'b100, 3'b010, 2'd2};
    tbl[8] = '{3'b100, 6'b10_00_00, 9'b0, 3'b000, 3'b100, 3'b100, 2'd2};
    tbl[9] = '{3'b000, 6'b00_00_00, 9'b0, 3'b000, 3'b100, 3'b000, 2'd2};

    // Reset held two cycles with active traffic.
    drive(1'b0, 3'b111, 6'b10_10_10, 9'b0, 3'b000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0);
      chk("rst_addr", addr_sel, 3'b001);
      chk("rst_data", data_sel, 3'b000);
      chk("rst_hmaster", {1'b0, hmaster}, 3'b000);
    end

    // Round-robin SINGLEs then an INCR4 handover.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].sel, tbl[i].trans, tbl[i].burst, 3'b000, 1'b1);
      #1;
      chk("tbl_stall", stall, tbl[i].exp_stall);
      model_step();
      @(posedge HCLK);
      #1;
      chk("tbl_addr", addr_sel, tbl[i].exp_addr);
      chk("tbl_data", data_sel, tbl[i].exp_data);
      chk("tbl_hmaster", {1'b0, hmaster}, {1'b0, tbl[i].exp_hm});
    end

    // WRAP8 by master 2 with three wait states after beat 4.
    drive(1'b1, 3'b101, 6'b10_00_10, 9'b100_000_000, 3'b000, 1'b1);
    cycle(1'b1);
    chk("wrap8_start", addr_sel, 3'b100);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b101, 6'b11_00_10, 9'b100_000_000, 3'b000, 1'b1);
      cycle(1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b101, 6'b11_00_10, 9'b100_000_000, 3'b000, 1'b0);
      cycle(1'b1);
      chk("ws_addr", addr_sel, 3'b100);
      chk("ws_data", data_sel, 3'b100);
    end
    for (int b = 5; b <= 8; b++) begin
      drive(1'b1, 3'b101, 6'b11_00_10, 9'b100_000_000, 3'b000, 1'b1);
      cycle(1'b1);
      if (b < 8) chk("wrap8_hold", addr_sel, 3'b100);
      else       chk("wrap8_handover", addr_sel, 3'b001);
    end

    // Master 0 locked across two INCR bursts while master 1 requests.
    drive(1'b1, 3'b011, 6'b00_10_10, 9'b000_000_001, 3'b001, 1'b1); cycle(1'b1);
    chk("lock_hold", addr_sel, 3'b001);
    drive(1'b1, 3'b011, 6'b00_10_11, 9'b000_000_001, 3'b001, 1'b1); cycle(1'b1);
    chk("lock_hold", addr_sel, 3'b001);
    drive(1'b1, 3'b011, 6'b00_10_10, 9'b000_000_001, 3'b001, 1'b1); cycle(1'b1);
    chk("lock_hold", addr_sel, 3'b001);
    drive(1'b1, 3'b011, 6'b00_10_11, 9'b000_000_001, 3'b001, 1'b1); cycle(1'b1);
    chk("lock_hold", addr_sel, 3'b001);
    drive(1'b1, 3'b011, 6'b00_10_00, 9'b000_000_001, 3'b001, 1'b1); cycle(1'b1);
    chk("lock_idle_hold", addr_sel, 3'b001);
    drive(1'b1, 3'b011, 6'b00_10_00, 9'b000_000_001, 3'b000, 1'b1); cycle(1'b1);
    chk("lock_release", addr_sel, 3'b010);

    // Reset at beat 2 of an INCR16 owned by master 2, with hready low.
    drive(1'b1, 3'b110, 6'b10_10_00, 9'b111_000_000, 3'b000, 1'b1); cycle(1'b1);
    chk("to_m2", addr_sel, 3'b100);
    drive(1'b1, 3'b100, 6'b10_00_00, 9'b111_000_000, 3'b000, 1'b1); cycle(1'b1);
    drive(1'b0, 3'b100, 6'b11_00_00, 9'b111_000_000, 3'b000, 1'b0); cycle(1'b1);
    chk("midrst_addr", addr_sel, 3'b001);
    chk("midrst_data", data_sel, 3'b000);
    drive(1'b1, 3'b100, 6'b11_00_00, 9'b111_000_000, 3'b000, 1'b1); cycle(1'b1);
    chk("midrst_idle_regrant", addr_sel, 3'b100);
    chk("midrst_idle_data", data_sel, 3'b000);

    // Simultaneous requests at reset release: master 0 first, then master 1.
    drive(1'b0, 3'b111, 6'b10_10_10, 9'b0, 3'b000, 1'b1); cycle(1'b0);
    drive(1'b1, 3'b111, 6'b10_10_10, 9'b0, 3'b000, 1'b1); cycle(1'b1);
    chk("rel_data_m0", data_sel, 3'b001);
    chk("rel_addr_m1", addr_sel, 3'b010);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [5:0] t;
      for (int m = 0; m < 3; m++) begin
        case ($urandom_range(0, 5))
          0:       t[2*m +: 2] = 2'b00;
          1:       t[2*m +: 2] = 2'b01;
          2:       t[2*m +: 2] = 2'b10;
          default: t[2*m +: 2] = 2'b11;
        endcase
      end
      drive(($urandom_range(0, 99) != 0), 3'($urandom_range(0, 7)), t,
            9'($urandom_range(0, 511)),
            {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0)},
            ($urandom_range(0, 4) != 0));
      cycle(HRESETn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
